fetch: RTL and testbench
========================

// Module: fetch
// PURPOSE
//  Instruction fetch stage; sits between ctrl (PC/soft-reset) and decode.
//  Issues in-order instruction-memory requests at ctrl's PC and reports each accepted request as i_m_hit_o (PC advance).
//  Buffers returned words with their PC in a small FIFO and pre-decodes rs1/rs2/rd for ctrl's RAW scoreboard.
//  Presents {instr, pc} to decode via valid/ready; flushes on ctrl's soft reset.
// PARAMETERS
//  AddrWidth    32  PC / memory address width
//  DataWidth    32  instruction word width
//  RfAddrWidth  5   GPR index width
//  FifoDepth    2   instruction buffer entries (power of 2, >=2); also max in-flight requests
// PORTS
//  clk_i          in   1            system clock
//  rst_i          in   1            synchronous active-high reset
//  softresetn_i   in   1            active-low one-cycle flush from ctrl (taken branch/jump)
//  pc_i           in   AddrWidth    current PC from ctrl
//  i_m_hit_o      out  1            request accepted this cycle (ctrl advances PC)
//  i_m_req_o      out  1            instruction memory request
//  i_m_addr_o     out  AddrWidth    request address (= pc_i)
//  i_m_gnt_i      in   1            memory accepts request this cycle
//  i_m_rvalid_i   in   1            read data valid (in order, >=1 cycle after grant)
//  i_m_rdata_i    in   DataWidth    read data
//  valid_o        out  1            FIFO head valid for decode
//  ready_i        in   1            decode accepts head
//  instr_o        out  DataWidth    head instruction
//  pc_o           out  AddrWidth    head instruction PC
//  rs1_o          out  RfAddrWidth  pre-decoded rs1 (0 if unused)
//  rs2_o          out  RfAddrWidth  pre-decoded rs2 (0 if unused)
//  rd_o           out  RfAddrWidth  pre-decoded rd (0 if none written)
// BEHAVIOUR
//  - Reset (rst_i=1): FIFO empty, outstanding=0, drop=0; valid_o=0, i_m_req_o=0, i_m_hit_o=0; instr_o/pc_o/rs*_o/rd_o=0.
//  - Request: i_m_req_o = !rst_i & softresetn_i & (count + outstanding < FifoDepth); i_m_addr_o = pc_i.
//  - i_m_hit_o = i_m_req_o & i_m_gnt_i; on hit, pc_i is pushed into a pending-PC queue and outstanding++.
//  - Response: i_m_rvalid_i pops the pending-PC queue, outstanding--.
//    If drop>0: word discarded, drop--. Otherwise push {rdata, pc} into FIFO.
//    Occupancy accounting guarantees no overflow.
//  - Decode handshake: transfer when valid_o & ready_i, head pops next edge.
//    Outputs are FIFO head (combinational from storage, no bubble).
//    Push+pop in the same cycle keeps count; pushing into an empty FIFO gives valid_o=1 next cycle (min latency gnt->valid_o = rvalid latency + 1).
//  - Flush (softresetn_i=0):
//    FIFO count->0; valid_o=0 next cycle; no request this cycle; pending-PC queue cleared.
//    drop_next = drop + outstanding - rvalid; outstanding_next = 0.
//    Any rvalid in the flush cycle is discarded.
//  - Pre-decode from head instr (opcode = instr[6:0]):
//    rd = instr[11:7], forced 0 for STORE 0100011 / BRANCH 1100011.
//    rs1 = instr[19:15], forced 0 for LUI 0110111 / AUIPC 0010111 / JAL 1101111.
//    rs2 = instr[24:20] only for OP 0110011 / STORE / BRANCH, else 0.
//    All three are 0 when valid_o=0.
//  - Counters are sized $clog2(FifoDepth)+1 bits; drop never exceeds FifoDepth.
//  - rvalid with outstanding=0 and drop=0 is illegal (assertion), not handled.
//  - Reset mid-flight: all state cleared; responses arriving after reset are illegal per memory contract.
// TESTING
//  1. Reset, gnt=1, rvalid 1 cycle after gnt, ready_i=1, pc_i 0x0,0x4,0x8 -> valid_o every cycle after cycle 2, pc_o 0x0,0x4,0x8 in order, i_m_hit_o=1 each cycle.
//  2. ready_i=0 with FifoDepth=2 -> after 2 hits i_m_req_o=0, valid_o=1 held, instr_o/pc_o stable; ready_i=1 -> request resumes next cycle.
//  3. Two requests outstanding (0x10,0x14), softresetn_i=0 pulse, pc_i=0x100 -> both late words dropped, first valid_o shows pc_o=0x100.
//  4. Flush in the same cycle as an rvalid with 1 more outstanding -> drop=1 next cycle, exactly one following word discarded.
//  5. Head = sw x5,0(x6) (0x00532023) -> rs1_o=6, rs2_o=5, rd_o=0.
//     lui x7 (0x000073B7) -> rs1_o=0, rs2_o=0, rd_o=7.
//  6. gnt held low 5 cycles -> i_m_req_o=1, i_m_addr_o stable, i_m_hit_o=0, outstanding unchanged.

Source files
------------

// File: rtl/fetch.sv
// Instruction fetch stage: issues in-order memory requests at ctrl's PC, buffers returned
// words with their PC, pre-decodes register indices and hands {instr, pc} to decode.
module fetch #(
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned RfAddrWidth = 5,
    parameter int unsigned FifoDepth   = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   softresetn_i,
    input  logic [AddrWidth-1:0]   pc_i,
    output logic                   i_m_hit_o,
    output logic                   i_m_req_o,
    output logic [AddrWidth-1:0]   i_m_addr_o,
    input  logic                   i_m_gnt_i,
    input  logic                   i_m_rvalid_i,
    input  logic [DataWidth-1:0]   i_m_rdata_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [DataWidth-1:0]   instr_o,
    output logic [AddrWidth-1:0]   pc_o,
    output logic [RfAddrWidth-1:0] rs1_o,
    output logic [RfAddrWidth-1:0] rs2_o,
    output logic [RfAddrWidth-1:0] rd_o
);

    localparam int unsigned PtrWidth = $clog2(FifoDepth);
    localparam int unsigned CntWidth = PtrWidth + 1;
    localparam logic [CntWidth:0] DepthExt = (CntWidth + 1)'(FifoDepth);

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpOp     = 7'b0110011;

    // Instruction buffer and the queue of PCs whose words are still in flight.
    logic [DataWidth-1:0] buf_instr_q [FifoDepth];
    logic [AddrWidth-1:0] buf_pc_q    [FifoDepth];
    logic [AddrWidth-1:0] pend_pc_q   [FifoDepth];

    logic [PtrWidth-1:0] buf_wptr_q, buf_wptr_d;
    logic [PtrWidth-1:0] buf_rptr_q, buf_rptr_d;
    logic [PtrWidth-1:0] pend_wptr_q, pend_wptr_d;
    logic [PtrWidth-1:0] pend_rptr_q, pend_rptr_d;
    logic [CntWidth-1:0] count_q, count_d;
    logic [CntWidth-1:0] outstanding_q, outstanding_d;
    logic [CntWidth-1:0] drop_q, drop_d;

    logic [CntWidth:0]   occupancy;
    logic [CntWidth:0]   drop_flush;
    logic                req;
    logic                hit;
    logic                valid;
    logic                xfer;
    logic                rsp_keep;
    logic                rsp_drop;
    logic                buf_push;
    logic [DataWidth-1:0] head_instr;
    logic [6:0]          opcode;

    // Buffered words plus words still owed by memory must fit in the buffer.
    assign occupancy  = {1'b0, count_q} + {1'b0, outstanding_q};
    assign req        = ~rst_i & softresetn_i & (occupancy < DepthExt);
    assign hit        = req & i_m_gnt_i;
    assign valid      = ~rst_i & (count_q != '0);
    assign xfer       = valid & ready_i;
    assign rsp_drop   = i_m_rvalid_i & (drop_q != '0);
    assign rsp_keep   = i_m_rvalid_i & (drop_q == '0);
    assign buf_push   = softresetn_i & rsp_keep;
    assign drop_flush = {1'b0, drop_q} + {1'b0, outstanding_q} - (CntWidth + 1)'(i_m_rvalid_i);

    assign i_m_req_o  = req;
    assign i_m_hit_o  = hit;
    assign i_m_addr_o = pc_i;

    always_comb begin
        buf_wptr_d    = buf_wptr_q;
        buf_rptr_d    = buf_rptr_q;
        pend_wptr_d   = pend_wptr_q;
        pend_rptr_d   = pend_rptr_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        if (!softresetn_i) begin
            // Everything still in flight becomes stale and must be discarded on return.
            buf_wptr_d    = '0;
            buf_rptr_d    = '0;
            pend_wptr_d   = '0;
            pend_rptr_d   = '0;
            count_d       = '0;
            outstanding_d = '0;
            drop_d        = drop_flush[CntWidth-1:0];
        end else begin
            if (buf_push) buf_wptr_d = buf_wptr_q + PtrWidth'(1);
            if (xfer) buf_rptr_d = buf_rptr_q + PtrWidth'(1);
            count_d = count_q + CntWidth'(buf_push) - CntWidth'(xfer);
            if (hit) pend_wptr_d = pend_wptr_q + PtrWidth'(1);
            if (rsp_keep) pend_rptr_d = pend_rptr_q + PtrWidth'(1);
            outstanding_d = outstanding_q + CntWidth'(hit) - CntWidth'(rsp_keep);
            if (rsp_drop) drop_d = drop_q - CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            buf_wptr_q    <= '0;
            buf_rptr_q    <= '0;
            pend_wptr_q   <= '0;
            pend_rptr_q   <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            buf_wptr_q    <= buf_wptr_d;
            buf_rptr_q    <= buf_rptr_d;
            pend_wptr_q   <= pend_wptr_d;
            pend_rptr_q   <= pend_rptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    // Storage needs no reset: outputs are masked whenever the buffer is empty.
    always_ff @(posedge clk_i) begin
        if (hit) begin
            pend_pc_q[pend_wptr_q] <= pc_i;
        end
        if (buf_push) begin
            buf_instr_q[buf_wptr_q] <= i_m_rdata_i;
            buf_pc_q[buf_wptr_q]    <= pend_pc_q[pend_rptr_q];
        end
    end

    assign valid_o    = valid;
    assign head_instr = valid ? buf_instr_q[buf_rptr_q] : '0;
    assign instr_o    = head_instr;
    assign pc_o       = valid ? buf_pc_q[buf_rptr_q] : '0;
    assign opcode     = head_instr[6:0];

    // An empty head reads as all-zero, so the indices fall to 0 without extra gating.
    always_comb begin
        rd_o  = RfAddrWidth'(head_instr[11:7]);
        rs1_o = RfAddrWidth'(head_instr[19:15]);
        rs2_o = '0;
        case (opcode)
            OpStore, OpBranch: begin
                rd_o  = '0;
                rs2_o = RfAddrWidth'(head_instr[24:20]);
            end
            OpOp: begin
                rs2_o = RfAddrWidth'(head_instr[24:20]);
            end
            OpLui, OpAuipc, OpJal: begin
                rs1_o = '0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(i_m_rvalid_i && outstanding_q == '0 && drop_q == '0));
            assert (softresetn_i || drop_flush <= DepthExt);
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Scoreboard bench for fetch: a ctrl/memory model drives the stage and a monitor checks
// every decode transfer against hand-computed expected words.
module tb_fetch;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        softresetn_i;
    logic [31:0] pc_i;
    logic        i_m_hit_o;
    logic        i_m_req_o;
    logic [31:0] i_m_addr_o;
    logic        i_m_gnt_i;
    logic        i_m_rvalid_i = 1'b0;
    logic [31:0] i_m_rdata_i = '0;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [4:0]  rs1_o;
    logic [4:0]  rs2_o;
    logic [4:0]  rd_o;

    always #5 clk_i = ~clk_i;

    fetch #(
        .AddrWidth  (32),
        .DataWidth  (32),
        .RfAddrWidth(5),
        .FifoDepth  (2)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .softresetn_i(softresetn_i),
        .pc_i        (pc_i),
        .i_m_hit_o   (i_m_hit_o),
        .i_m_req_o   (i_m_req_o),
        .i_m_addr_o  (i_m_addr_o),
        .i_m_gnt_i   (i_m_gnt_i),
        .i_m_rvalid_i(i_m_rvalid_i),
        .i_m_rdata_i (i_m_rdata_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .instr_o     (instr_o),
        .pc_o        (pc_o),
        .rs1_o       (rs1_o),
        .rs2_o       (rs2_o),
        .rd_o        (rd_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    exp_t  exp_q[$];
    mreq_t mem_q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    lat = 1;
    bit    hit_seen = 1'b0;
    int    first_hit = -1;
    int    first_valid = -1;

    function automatic logic [31:0] imem(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: return 32'h0053_2023;  // sw x5,0(x6)
            32'h0000_0004: return 32'h0000_73B7;  // lui x7,0x7
            32'h0000_0008: return 32'h0020_81B3;  // add x3,x1,x2
            32'h0000_000C: return 32'h0020_8463;  // beq x1,x2,+8
            32'h0000_0100: return 32'h000F_F0EF;  // jal x1 with imm bits in rs1 field
            32'h0000_0104: return 32'h1234_53B7;  // lui x7,0x12345
            default:       return {addr[11:0], 20'h0_0013};  // addi x0,x0,addr
        endcase
    endfunction

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] instr,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd);
        exp_t e;
        e.pc = pc;
        e.instr = instr;
        e.rs1 = rs1;
        e.rs2 = rs2;
        e.rd = rd;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Sample point: 1 time unit before each rising edge.
    always begin
        @(negedge clk_i);
        #4;
        cyc++;
        if (i_m_hit_o === 1'b1) begin
            mem_q.push_back('{addr: i_m_addr_o, due: cyc + lat});
            hit_seen = 1'b1;
            if (first_hit < 0) first_hit = cyc;
        end
        if (valid_o === 1'b1 && first_valid < 0) first_valid = cyc;
    end

    // Memory: in-order responses, lat cycles after grant.
    always @(negedge clk_i) begin
        if (mem_q.size() > 0 && mem_q[0].due <= cyc + 1) begin
            i_m_rvalid_i = 1'b1;
            i_m_rdata_i  = imem(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            i_m_rvalid_i = 1'b0;
            i_m_rdata_i  = '0;
        end
    end

    // Monitor / scoreboard.
    always begin
        exp_t e;
        @(negedge clk_i);
        #4;
        if (valid_o === 1'b1 && ready_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: actual pc_o %0h, required no transfer", pc_o);
            end else begin
                e = exp_q.pop_front();
                check("pc_o", pc_o, e.pc);
                check("instr_o", instr_o, e.instr);
                check("rs1_o", 32'(rs1_o), 32'(e.rs1));
                check("rs2_o", 32'(rs2_o), 32'(e.rs2));
                check("rd_o", 32'(rd_o), 32'(e.rd));
            end
        end
    end

    // ctrl model: PC advances by 4 for every accepted request.
    task automatic tick();
        @(negedge clk_i);
        if (hit_seen) begin
            pc_i = pc_i + 32'd4;
            hit_seen = 1'b0;
        end
    endtask

    task automatic run_until_pc(input string name, input logic [31:0] target);
        int i = 0;
        while (pc_i != target && i < 50) begin
            tick();
            i++;
        end
        check(name, pc_i, target);
    endtask

    task automatic drain(input string name);
        int i = 0;
        while ((exp_q.size() != 0 || mem_q.size() != 0) && i < 50) begin
            tick();
            i++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        softresetn_i = 1'b1;
        pc_i = '0;
        i_m_gnt_i = 1'b1;
        ready_i = 1'b1;

        // Reset state
        repeat (3) tick();
        #4;
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_req", 32'(i_m_req_o), 32'd0);
        check("rst_hit", 32'(i_m_hit_o), 32'd0);
        check("rst_instr", instr_o, 32'd0);
        check("rst_pc", pc_o, 32'd0);
        check("rst_rd", 32'(rd_o), 32'd0);

        // Streaming fetch with 1-cycle memory; covers sw / lui / add pre-decode
        tick();
        rst_i = 1'b0;
        lat = 1;
        exp_q.push_back(mk(32'h0, 32'h0053_2023, 5'd6, 5'd5, 5'd0));
        exp_q.push_back(mk(32'h4, 32'h0000_73B7, 5'd0, 5'd0, 5'd7));
        exp_q.push_back(mk(32'h8, 32'h0020_81B3, 5'd1, 5'd2, 5'd3));
        run_until_pc("stream_hits", 32'hC);
        i_m_gnt_i = 1'b0;
        drain("stream_drain");
        check("gnt_to_valid_latency", 32'(first_valid - first_hit), 32'd2);
        #4;
        check("idle_valid", 32'(valid_o), 32'd0);
        check("idle_rs1", 32'(rs1_o), 32'd0);
        check("idle_rs2", 32'(rs2_o), 32'd0);
        check("idle_rd", 32'(rd_o), 32'd0);

        // Grant held low: request stays up with a stable address
        for (int i = 0; i < 5; i++) begin
            tick();
            #4;
            check("nognt_req", 32'(i_m_req_o), 32'd1);
            check("nognt_addr", i_m_addr_o, 32'hC);
            check("nognt_hit", 32'(i_m_hit_o), 32'd0);
        end
        tick();
        i_m_gnt_i = 1'b1;
        exp_q.push_back(mk(32'hC, 32'h0020_8463, 5'd1, 5'd2, 5'd0));
        run_until_pc("nognt_resume", 32'h10);
        i_m_gnt_i = 1'b0;
        drain("nognt_drain");

        // Back-pressure: buffer fills, requests stop, head holds
        tick();
        pc_i = 32'h20;
        ready_i = 1'b0;
        i_m_gnt_i = 1'b1;
        exp_q.push_back(mk(32'h20, 32'h0200_0013, 5'd0, 5'd0, 5'd0));
        exp_q.push_back(mk(32'h24, 32'h0240_0013, 5'd0, 5'd0, 5'd0));
        repeat (6) tick();
        #4;
        check("full_hits", pc_i, 32'h28);
        check("full_req", 32'(i_m_req_o), 32'd0);
        check("full_valid", 32'(valid_o), 32'd1);
        check("full_pc", pc_o, 32'h20);
        check("full_instr", instr_o, 32'h0200_0013);
        tick();
        #4;
        check("hold_valid", 32'(valid_o), 32'd1);
        check("hold_pc", pc_o, 32'h20);
        tick();
        ready_i = 1'b1;
        i_m_gnt_i = 1'b0;
        #4;
        check("pop_cycle_req", 32'(i_m_req_o), 32'd0);
        tick();
        #4;
        check("resume_req", 32'(i_m_req_o), 32'd1);
        drain("bp_drain");

        // Flush with two requests outstanding: both late words dropped
        tick();
        lat = 3;
        pc_i = 32'h10;
        i_m_gnt_i = 1'b1;
        run_until_pc("flush2_hits", 32'h18);
        softresetn_i = 1'b0;
        pc_i = 32'h100;
        #4;
        check("flush_req", 32'(i_m_req_o), 32'd0);
        check("flush_hit", 32'(i_m_hit_o), 32'd0);
        tick();
        softresetn_i = 1'b1;
        exp_q.push_back(mk(32'h100, 32'h000F_F0EF, 5'd0, 5'd0, 5'd1));
        exp_q.push_back(mk(32'h104, 32'h1234_53B7, 5'd0, 5'd0, 5'd7));
        run_until_pc("flush2_refetch", 32'h108);
        i_m_gnt_i = 1'b0;
        drain("flush2_drain");

        // Flush coinciding with an rvalid and one more outstanding
        tick();
        lat = 2;
        pc_i = 32'h30;
        i_m_gnt_i = 1'b1;
        run_until_pc("flush1_hits", 32'h38);
        softresetn_i = 1'b0;
        pc_i = 32'h40;
        #4;
        check("flush_rv_req", 32'(i_m_req_o), 32'd0);
        tick();
        softresetn_i = 1'b1;
        exp_q.push_back(mk(32'h40, 32'h0400_0013, 5'd0, 5'd0, 5'd0));
        exp_q.push_back(mk(32'h44, 32'h0440_0013, 5'd0, 5'd0, 5'd0));
        run_until_pc("flush1_refetch", 32'h48);
        i_m_gnt_i = 1'b0;
        drain("flush1_drain");

        repeat (3) tick();
        #4;
        check("end_valid", 32'(valid_o), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
